cmd_packet_rx: RTL and testbench
================================

# cmd_packet_rx

Byte-stream framer sitting between the host link receiver (UART/SPI byte output) and the command decoder. It assembles `[opcode][len][payload…][chk]` packets and forwards payload bytes to the data sinks (vertex/edge loaders). On a complete, valid packet it presents the opcode together with a one-cycle `packet_ready` strobe, which the command decoder samples. It enforces a maximum length and an inter-byte timeout, so a broken host transfer cannot wedge the command path.

## Interface
- `MAX_LEN`, default 16: largest legal payload length in bytes (1..255).
- `TIMEOUT_CYC`, default 100000: idle CLK cycles allowed between bytes of one packet.
- `CLK` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` holds a new byte.
- `rx_data` in 8: received byte.
- `packet_ready` out 1: one-cycle strobe; the packet is complete and valid.
- `opcode` out 8: opcode of the current or last packet; stable while `packet_ready` is high.
- `length` out 8: payload length of the current or last packet.
- `payload_valid` out 1: one-cycle strobe per forwarded payload byte.
- `payload_data` out 8: forwarded payload byte.
- `err_len` out 1: one-cycle strobe; `len` > `MAX_LEN`.
- `err_timeout` out 1: one-cycle strobe; inter-byte timeout expired.
- `err_chk` out 1: one-cycle strobe; checksum mismatch. This port is tied to 0 when the checksum is compiled out.

## Operation
- States: `IDLE`, `LEN`, `PAYLOAD`, `CHK`, `DISCARD`.
- `IDLE`: on an accepted byte, latch `opcode`, clear the byte counter, and go to `LEN`.
- `LEN`: latch `length`.
  - If `len` > `MAX_LEN`: pulse `err_len` and go to `DISCARD` with `len` bytes to swallow (plus 1 if `CMD_PKT_CHECKSUM_EN` is defined).
  - Else if `len` == 0: go to `CHK` (checksum build) or complete the packet (no checksum).
  - Else: go to `PAYLOAD`.
- `PAYLOAD`: each accepted byte is registered to `payload_data` with `payload_valid`=1 for one cycle, and the counter increments.
  - After byte number `length`, go to `CHK` or complete the packet.
- `CHK`: compare the accepted byte against the running XOR of opcode, len and all payload bytes.
  - Equal: complete the packet.
  - Not equal: pulse `err_chk`, return to `IDLE`, no `packet_ready`.
- Complete: pulse `packet_ready` and return to `IDLE`.
- `DISCARD`: count accepted bytes without forwarding them, then return to `IDLE`. No strobes.
- Payload is forwarded before checksum validation. Sinks drop data when `err_chk` pulses instead of `packet_ready`.
- Timeout counter:
  - Cleared on every accepted byte and held at 0 in `IDLE`.
  - Otherwise increments each cycle.
  - On reaching `TIMEOUT_CYC`-1: pulse `err_timeout` and go to `IDLE`.
- Counter width is `$clog2(TIMEOUT_CYC+1)`. The byte counter is 8 bits and never wraps, because `len` ≤ 255.

## Timing
- All outputs are registered.
- Reset values: every output is 0, including `opcode`, `length` and `payload_data`. State is `IDLE`.
- `payload_valid` is asserted the cycle after the payload byte's `rx_valid`.
- `packet_ready` is asserted the cycle after the last byte's `rx_valid`:
  - the checksum byte, when the checksum is enabled;
  - otherwise the last payload byte, or the len byte when `len` == 0.
- `opcode` and `length` change only when their bytes are accepted, so they stay stable from `packet_ready` until the next packet's bytes arrive.
- Back-to-back packets are accepted with `rx_valid` on consecutive cycles. There is no dead cycle after completion.
- If `rx_valid` arrives in the same cycle the timeout would expire, the byte wins: it is accepted and there is no `err_timeout`.
- At most one error strobe fires per cycle. No error strobe fires in the same cycle as `packet_ready`.
- `rst` mid-packet: return to `IDLE` on the next edge, with no strobes and partial data dropped.

## Configuration
- `CMD_PKT_CHECKSUM_EN` defined:
  - the trailing XOR checksum byte is expected and checked;
  - `CHK` state and `err_chk` are active;
  - `DISCARD` also swallows the checksum byte.
- Not defined:
  - there is no checksum byte, and `CHK` is not built;
  - `err_chk` is constant 0;
  - packets end at the last payload byte.

## Test plan
- Checksum off, bytes 0x03,0x02,0xAA,0x55:
  - `payload_valid` pulses carry 0xAA then 0x55;
  - `packet_ready`=1 one cycle after the 0x55 byte, with `opcode`=0x03 and `length`=2.
- Checksum on, bytes 0x01,0x00,0x01 (XOR = 0x01): `packet_ready` is asserted. Then bytes 0x01,0x00,0x02: `err_chk` pulses and there is no `packet_ready`.
- `MAX_LEN`=16, bytes 0x05,0x11 followed by 17 filler bytes (18 with checksum on), then 0x07,0x00:
  - `err_len` pulses once;
  - the filler bytes are not forwarded;
  - then `packet_ready` fires with `opcode`=0x07.
- `TIMEOUT_CYC`=8, bytes 0x03,0x04,0x10 then silence: `err_timeout` pulses 8 cycles after 0x10. A subsequent 0x02,0x00 completes normally.
- Timeout collision: deliver a byte exactly in the expiring cycle. The byte is accepted and no `err_timeout` fires.
- Assert `rst` after 0x03,0x04,0x10:
  - all outputs are 0 the cycle after reset;
  - a fresh 0x02,0x00 yields `packet_ready` with `opcode`=0x02.

Source files
------------

// File: rtl/cmd_packet_rx.sv
// cmd_packet_rx: [opcode][len][payload][chk] framer with length/timeout guards; define CMD_PKT_CHECKSUM_EN for the XOR checksum byte
module cmd_packet_rx #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       packet_ready,
  output logic [7:0] opcode,
  output logic [7:0] length,
  output logic       payload_valid,
  output logic [7:0] payload_data,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_chk
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [2:0] IDLE = 3'd0, LEN = 3'd1, PAYLOAD = 3'd2, DISCARD = 3'd4;
  logic [2:0] state;
  logic [7:0] bcnt, disc_last;
  logic [TW-1:0] tcnt;
  logic expire;
`ifdef CMD_PKT_CHECKSUM_EN
  localparam logic [2:0] CHK = 3'd3, END_ST = CHK;
  logic [7:0] sum;
  assign disc_last = length;
  always_ff @(posedge CLK)
    sum <= rst ? '0 : rx_valid ? (state == IDLE ? rx_data : sum ^ rx_data) : sum;
`else
  localparam logic [2:0] END_ST = IDLE;
  assign disc_last = length - 8'd1;
  assign err_chk = 1'b0;
`endif
  // an arriving byte beats an expiring timeout
  assign expire = state != IDLE && !rx_valid && tcnt == T_LAST;
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      bcnt <= '0;
      tcnt <= '0;
      opcode <= '0;
      length <= '0;
      payload_data <= '0;
      packet_ready <= 1'b0;
      payload_valid <= 1'b0;
      err_len <= 1'b0;
      err_timeout <= 1'b0;
`ifdef CMD_PKT_CHECKSUM_EN
      err_chk <= 1'b0;
`endif
    end else begin
      packet_ready <= 1'b0;
      payload_valid <= 1'b0;
      err_len <= 1'b0;
      err_timeout <= expire;
`ifdef CMD_PKT_CHECKSUM_EN
      err_chk <= 1'b0;
`endif
      tcnt <= (state == IDLE || rx_valid || expire) ? '0 : tcnt + 1'b1;
      if (expire) state <= IDLE;
      else if (rx_valid) begin
        case (state)
          IDLE: begin
            opcode <= rx_data;
            bcnt <= '0;
            state <= LEN;
          end
          LEN: begin
            length <= rx_data;
            if (rx_data > MAX_B) begin
              err_len <= 1'b1;
              state <= DISCARD;
            end else if (rx_data == 8'd0) begin
              state <= END_ST;
              packet_ready <= END_ST == IDLE;
            end else state <= PAYLOAD;
          end
          PAYLOAD: begin
            payload_data <= rx_data;
            payload_valid <= 1'b1;
            bcnt <= bcnt + 8'd1;
            if (bcnt == length - 8'd1) begin
              state <= END_ST;
              packet_ready <= END_ST == IDLE;
            end
          end
          DISCARD: begin
            bcnt <= bcnt + 8'd1;
            if (bcnt == disc_last) state <= IDLE;
          end
`ifdef CMD_PKT_CHECKSUM_EN
          CHK: begin
            packet_ready <= rx_data == sum;
            err_chk <= rx_data != sum;
            state <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_packet_rx.sv
// tb_cmd_packet_rx: table-driven check of cmd_packet_rx with MAX_LEN=16, TIMEOUT_CYC=8
module tb_cmd_packet_rx;
  logic CLK = 0, rst = 1, rx_valid = 0;
  logic [7:0] rx_data = '0;
  logic packet_ready, payload_valid, err_len, err_timeout, err_chk;
  logic [7:0] opcode, length, payload_data;
  int checks = 0, errors = 0;

  cmd_packet_rx #(.MAX_LEN(16), .TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .packet_ready(packet_ready), .opcode(opcode), .length(length),
    .payload_valid(payload_valid), .payload_data(payload_data),
    .err_len(err_len), .err_timeout(err_timeout), .err_chk(err_chk)
  );

  always #5 CLK = ~CLK;

  localparam logic [4:0] NO = 5'b00000, PR = 5'b10000, PV = 5'b01000, EL = 5'b00100, ET = 5'b00010, EC = 5'b00001;
`ifdef CMD_PKT_CHECKSUM_EN
  localparam bit CK = 1;
`else
  localparam bit CK = 0;
`endif

  typedef struct {
    logic v;
    logic [7:0] d;
    logic [4:0] s;
    logic [7:0] pd;
    logic ol;
    logic [7:0] op;
    logic [7:0] ln;
  } vec_t;
  vec_t vq[$];

  function automatic void add(logic v, logic [7:0] d, logic [4:0] s, logic [7:0] pd = 0,
                              logic ol = 0, logic [7:0] op = 0, logic [7:0] ln = 0);
    vq.push_back('{v, d, s, pd, ol, op, ln});
  endfunction

  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(logic v, logic [7:0] d);
    rx_valid = v;
    rx_data = d;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] strb();
    return {3'b0, packet_ready, payload_valid, err_len, err_timeout, err_chk};
  endfunction

  initial begin
    // basic packet: payload forwarded, completion on last byte (or checksum byte)
    add(1, 8'h03, NO);
    add(1, 8'h02, NO);
    add(1, 8'hAA, PV, 8'hAA);
    if (CK) begin
      add(1, 8'h55, PV, 8'h55);
      add(1, 8'hFE, PR, 0, 1, 8'h03, 8'h02);
    end else add(1, 8'h55, PR | PV, 8'h55, 1, 8'h03, 8'h02);
    add(0, 8'h00, NO);
    add(0, 8'h00, NO);
    // zero-length packets; good then bad checksum when enabled
    add(1, 8'h01, NO);
    if (CK) begin
      add(1, 8'h00, NO);
      add(1, 8'h01, PR, 0, 1, 8'h01, 8'h00);
      add(1, 8'h01, NO);
      add(1, 8'h00, NO);
      add(1, 8'h02, EC);
    end else add(1, 8'h00, PR, 0, 1, 8'h01, 8'h00);
    // oversize length: discard then back-to-back valid packet
    add(1, 8'h05, NO);
    add(1, 8'h11, EL, 0, 1, 8'h05, 8'h11);
    for (int i = 0; i < 17 + int'(CK); i++) add(1, 8'hC0 + 8'(i), NO);
    add(1, 8'h07, NO);
    if (CK) begin
      add(1, 8'h00, NO);
      add(1, 8'h07, PR, 0, 1, 8'h07, 8'h00);
    end else add(1, 8'h00, PR, 0, 1, 8'h07, 8'h00);
    // timeout: 8 edges after the last accepted byte
    add(1, 8'h03, NO);
    add(1, 8'h04, NO);
    add(1, 8'h10, PV, 8'h10);
    for (int i = 0; i < 7; i++) add(0, 8'h00, NO);
    add(0, 8'h00, ET);
    add(1, 8'h02, NO);
    if (CK) begin
      add(1, 8'h00, NO);
      add(1, 8'h02, PR, 0, 1, 8'h02, 8'h00);
    end else add(1, 8'h00, PR, 0, 1, 8'h02, 8'h00);
    // byte arrives in the expiring cycle and wins
    add(1, 8'h03, NO);
    add(1, 8'h04, NO);
    add(1, 8'h10, PV, 8'h10);
    for (int i = 0; i < 7; i++) add(0, 8'h00, NO);
    add(1, 8'h20, PV, 8'h20);
    add(1, 8'h30, PV, 8'h30);
    if (CK) begin
      add(1, 8'h40, PV, 8'h40);
      add(1, 8'h47, PR, 0, 1, 8'h03, 8'h04);
    end else add(1, 8'h40, PR | PV, 8'h40, 1, 8'h03, 8'h04);
    add(0, 8'h00, NO);

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_strobes", 0, strb(), 8'h00);
    chk("reset_opcode", 0, opcode, 8'h00);
    chk("reset_length", 0, length, 8'h00);
    chk("reset_payload_data", 0, payload_data, 8'h00);
    rst = 0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].v, vq[i].d);
      chk("strobes", i, strb(), {3'b0, vq[i].s});
      if (vq[i].s[3]) chk("payload_data", i, payload_data, vq[i].pd);
      if (vq[i].ol) begin
        chk("opcode", i, opcode, vq[i].op);
        chk("length", i, length, vq[i].ln);
      end
    end

    // reset in the middle of a packet
    step(1, 8'h03);
    step(1, 8'h04);
    step(1, 8'h10);
    chk("pre_rst_pv", 0, strb(), {3'b0, PV});
    rst = 1;
    step(0, 8'h00);
    chk("rst_strobes", 0, strb(), 8'h00);
    chk("rst_opcode", 0, opcode, 8'h00);
    chk("rst_length", 0, length, 8'h00);
    chk("rst_payload_data", 0, payload_data, 8'h00);
    rst = 0;
    step(1, 8'h02);
    step(1, 8'h00);
    if (CK) step(1, 8'h02);
    chk("post_rst_strobes", 0, strb(), {3'b0, PR});
    chk("post_rst_opcode", 0, opcode, 8'h02);
    step(0, 8'h00);
    chk("post_rst_idle", 0, strb(), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
